// File: rtl/labels_wr_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// labels_wr_ctrl_pkg
//
// Shared definitions for the labels RAM write controller: the command byte
// codes of the UART command stream, the lowest printable character code and
// the controller state encoding.
// -----------------------------------------------------------------------------
package labels_wr_ctrl_pkg;

    // Command byte codes recognised in IDLE.
    localparam logic [7:0] CMD_SET_ADDR = 8'h01;
    localparam logic [7:0] CMD_FILL     = 8'h02;
    localparam logic [7:0] CMD_CLEAR    = 8'h0C;

    // Bytes at or above this value are printable characters.
    localparam logic [7:0] CHAR_MIN     = 8'h20;

    // Controller states.
    //   ST_IDLE  : waiting for a command or character byte
    //   ST_ADDR  : next byte is the new cursor
    //   ST_FVAL  : next byte is the fill value
    //   ST_FCNT  : next byte is the fill count
    //   ST_WRITE : single character write pending
    //   ST_FILL  : fill/clear burst in progress
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ADDR  = 3'd1,
        ST_FVAL  = 3'd2,
        ST_FCNT  = 3'd3,
        ST_WRITE = 3'd4,
        ST_FILL  = 3'd5
    } state_t;

endpackage : labels_wr_ctrl_pkg

// File: rtl/labels_wr_ctrl.sv
// -----------------------------------------------------------------------------
// labels_wr_ctrl
//
// Write controller and address-port arbiter for the on-screen labels RAM.
// Parses a byte command stream into character writes, cursor moves, fills
// and a full-screen clear, and shares the RAM's single address port with
// the VGA read path. VGA reads always win; a pending write waits for a
// cycle in which the VGA pipe is not reading.
//
// Parameters
//   AW         : RAM address width; cursor and fill addresses wrap mod 2^AW
//   DW         : RAM data width (also the command byte width)
//   BLANK_CHAR : value written by CLEAR
//
// Ports
//   i_clk         in   pixel clock
//   i_rst         in   synchronous active-high reset
//   i_wr          in   command/data byte valid from the upstream FIFO
//   i_data        in   command/data byte
//   o_ready       out  byte consumed when i_wr & o_ready
//   i_vga_busy    in   VGA pipe owns the RAM address this cycle
//   i_vga_addr    in   VGA read address
//   o_ram_addr    out  RAM address (VGA address unless a write is granted)
//   o_ram_we      out  RAM write enable
//   o_ram_din     out  RAM write data
//   o_cursor      out  current write cursor
//   o_fill_active out  high while a FILL or CLEAR burst is in progress
// -----------------------------------------------------------------------------
module labels_wr_ctrl
    import labels_wr_ctrl_pkg::*;
#(
    parameter int              AW         = 8,
    parameter int              DW         = 8,
    parameter logic [DW-1:0]   BLANK_CHAR = 8'h20
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_wr,
    input  logic [DW-1:0] i_data,
    output logic          o_ready,
    input  logic          i_vga_busy,
    input  logic [AW-1:0] i_vga_addr,
    output logic [AW-1:0] o_ram_addr,
    output logic          o_ram_we,
    output logic [DW-1:0] o_ram_din,
    output logic [AW-1:0] o_cursor,
    output logic          o_fill_active
);

    // A count of 2^AW needs the extra MSB of the count register.
    localparam logic [AW:0] COUNT_FULL = {1'b1, {AW{1'b0}}};
    localparam logic [AW:0] COUNT_ONE  = (AW+1)'(1);

    state_t        state;
    logic [AW-1:0] cursor;
    logic [AW-1:0] fill_addr;   // next address of the running burst
    logic [AW:0]   count;       // writes still owed by the running burst
    logic [DW-1:0] wdata;       // pending character or fill value

    logic          accept;
    logic          grant;
    logic          write_pending;
    logic [AW-1:0] write_addr;

    // -------------------------------------------------------------------------
    // Handshake and arbitration
    // -------------------------------------------------------------------------
    assign o_ready       = (state == ST_IDLE) || (state == ST_ADDR) ||
                           (state == ST_FVAL) || (state == ST_FCNT);
    assign o_fill_active = (state == ST_FILL);
    assign accept        = i_wr && o_ready;

    // The reset term keeps the RAM untouched on the reset cycle itself,
    // while the state register still holds WRITE or FILL.
    assign write_pending = (state == ST_WRITE) || (state == ST_FILL);
    assign grant         = write_pending && !i_vga_busy && !i_rst;

    assign write_addr    = (state == ST_FILL) ? fill_addr : cursor;

    assign o_ram_we      = grant;
    assign o_ram_addr    = grant ? write_addr : i_vga_addr;
    assign o_ram_din     = wdata;
    assign o_cursor      = cursor;

    // -------------------------------------------------------------------------
    // Command parser / write sequencer
    // -------------------------------------------------------------------------
    // NOTE: every register here is assigned with <= so all of them update
    // together from the pre-edge values; a blocking = would let later
    // statements see half-updated state and change behaviour with ordering.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state     <= ST_IDLE;
            cursor    <= '0;
            fill_addr <= '0;
            count     <= '0;
            wdata     <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        if (i_data == DW'(CMD_SET_ADDR)) begin
                            state <= ST_ADDR;
                        end else if (i_data == DW'(CMD_FILL)) begin
                            state <= ST_FVAL;
                        end else if (i_data == DW'(CMD_CLEAR)) begin
                            // CLEAR is a full-size fill from address 0; the
                            // burst ends with fill_addr wrapped back to 0,
                            // which is what the cursor is left at.
                            wdata     <= BLANK_CHAR;
                            fill_addr <= '0;
                            count     <= COUNT_FULL;
                            state     <= ST_FILL;
                        end else if (i_data >= DW'(CHAR_MIN)) begin
                            wdata <= i_data;
                            state <= ST_WRITE;
                        end
                        // Remaining control codes are swallowed silently.
                    end
                end

                ST_ADDR: begin
                    if (accept) begin
                        cursor <= AW'(i_data);
                        state  <= ST_IDLE;
                    end
                end

                ST_FVAL: begin
                    if (accept) begin
                        wdata <= i_data;
                        state <= ST_FCNT;
                    end
                end

                ST_FCNT: begin
                    if (accept) begin
                        count     <= (i_data == '0) ? COUNT_FULL
                                                    : (AW+1)'(i_data);
                        fill_addr <= cursor;
                        state     <= ST_FILL;
                    end
                end

                ST_WRITE: begin
                    if (grant) begin
                        cursor <= cursor + AW'(1);
                        state  <= ST_IDLE;
                    end
                end

                ST_FILL: begin
                    if (count == '0) begin
                        state <= ST_IDLE;
                    end else if (grant) begin
                        fill_addr <= fill_addr + AW'(1);
                        count     <= count - COUNT_ONE;
                        if (count == COUNT_ONE) begin
                            // Last write: the cursor lands just past the
                            // burst, i.e. start + C modulo 2^AW.
                            cursor <= fill_addr + AW'(1);
                            state  <= ST_IDLE;
                        end
                    end
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule : labels_wr_ctrl

// File: tb/tb_labels_wr_ctrl.sv
// -----------------------------------------------------------------------------
// tb_labels_wr_ctrl
//
// Scoreboard bench for labels_wr_ctrl. The stimulus process pushes every RAM
// write it expects (address, data) into a queue before sending the bytes; a
// monitor process pops and compares on each cycle the DUT raises o_ram_we,
// and on all other cycles checks that the RAM address follows the VGA path.
// Inputs change 1 time unit after the rising edge; outputs are sampled on
// the falling edge.
// -----------------------------------------------------------------------------
module tb_labels_wr_ctrl;

    logic       i_clk = 1'b0;
    logic       i_rst;
    logic       i_wr;
    logic [7:0] i_data;
    logic       o_ready;
    logic       i_vga_busy;
    logic [7:0] i_vga_addr;
    logic [7:0] o_ram_addr;
    logic       o_ram_we;
    logic [7:0] o_ram_din;
    logic [7:0] o_cursor;
    logic       o_fill_active;

    always #5 i_clk = ~i_clk;

    labels_wr_ctrl #(
        .AW        (8),
        .DW        (8),
        .BLANK_CHAR(8'h20)
    ) dut (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_wr         (i_wr),
        .i_data       (i_data),
        .o_ready      (o_ready),
        .i_vga_busy   (i_vga_busy),
        .i_vga_addr   (i_vga_addr),
        .o_ram_addr   (o_ram_addr),
        .o_ram_we     (o_ram_we),
        .o_ram_din    (o_ram_din),
        .o_cursor     (o_cursor),
        .o_fill_active(o_fill_active)
    );

    typedef struct packed {
        logic [7:0] addr;
        logic [7:0] data;
    } wr_t;

    wr_t sb[$];
    int  checks      = 0;
    int  failures    = 0;
    int  busy_mode   = 0;   // 0: idle, 1: held high, 2: toggle each cycle
    bit  mon_en      = 1'b0;
    int  writes      = 0;
    int  fill_cycles = 0;
    int  fill_busy   = 0;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // VGA side: address sweeps every cycle, busy follows busy_mode.
    initial begin
        i_vga_busy = 1'b0;
        i_vga_addr = 8'h5A;
        forever begin
            @(posedge i_clk);
            #1;
            i_vga_addr = i_vga_addr + 8'd37;
            case (busy_mode)
                1:       i_vga_busy = 1'b1;
                2:       i_vga_busy = ~i_vga_busy;
                default: i_vga_busy = 1'b0;
            endcase
        end
    end

    // Monitor / scoreboard consumer.
    initial begin
        forever begin
            @(negedge i_clk);
            if (mon_en) begin
                if (o_fill_active === 1'b1) begin
                    fill_cycles++;
                    if (i_vga_busy) fill_busy++;
                end
                if (o_ram_we === 1'b1) begin
                    writes++;
                    check("we_while_busy", i_vga_busy, 0);
                    check("sb_nonempty", (sb.size() > 0), 1);
                    if (sb.size() > 0) begin
                        wr_t e;
                        e = sb.pop_front();
                        check("wr_addr", o_ram_addr, e.addr);
                        check("wr_data", o_ram_din, e.data);
                    end
                end else begin
                    check("addr_follows_vga", o_ram_addr, i_vga_addr);
                end
            end
        end
    end

    // Watchdog so the run always ends.
    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n);
        repeat (n) @(posedge i_clk);
        #1;
    endtask

    task automatic expect_wr(input logic [7:0] a, input logic [7:0] d);
        wr_t e;
        e.addr = a;
        e.data = d;
        sb.push_back(e);
    endtask

    // Present one byte and hold it until the DUT takes it (bounded).
    task automatic send_byte(input logic [7:0] b);
        int n;
        n      = 0;
        i_wr   = 1'b1;
        i_data = b;
        @(negedge i_clk);
        while (o_ready !== 1'b1 && n < 2000) begin
            @(negedge i_clk);
            n++;
        end
        check("byte_accept", o_ready, 1);
        @(posedge i_clk);
        #1;
        i_wr = 1'b0;
    endtask

    // Wait until every expected write has been seen and the DUT is idle.
    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        do begin
            @(negedge i_clk);
            n++;
        end while (!(sb.size() == 0 && o_ready === 1'b1 && o_ram_we === 1'b0)
                   && n < budget);
        check("drain", sb.size(), 0);
        check("ready_after", o_ready, 1);
        @(posedge i_clk);
        #1;
    endtask

    initial begin
        int base;
        int n;

        i_rst  = 1'b1;
        i_wr   = 1'b0;
        i_data = 8'h00;
        tick(3);

        // Reset state (reset still asserted).
        check("rst_ready", o_ready, 1);
        check("rst_we", o_ram_we, 0);
        check("rst_fill", o_fill_active, 0);
        check("rst_din", o_ram_din, 8'h00);
        check("rst_cursor", o_cursor, 8'h00);
        check("rst_addr", o_ram_addr, i_vga_addr);
        i_rst  = 1'b0;
        mon_en = 1'b1;
        tick(1);

        // 'A' then 'B' with the VGA path idle, including write latency.
        base = writes;
        expect_wr(8'h00, 8'h41);
        send_byte(8'h41);
        @(negedge i_clk);
        check("a_we_n1", o_ram_we, 1);
        check("a_ready_n1", o_ready, 0);
        check("a_cursor_n1", o_cursor, 8'h00);
        @(negedge i_clk);
        check("a_we_n2", o_ram_we, 0);
        check("a_ready_n2", o_ready, 1);
        check("a_cursor_n2", o_cursor, 8'h01);
        tick(1);
        expect_wr(8'h01, 8'h42);
        send_byte(8'h42);
        wait_idle(50);
        check("ab_writes", writes - base, 2);
        check("ab_cursor", o_cursor, 8'h02);

        // 'Z' with the VGA path busy: the write must wait.
        busy_mode = 1;
        tick(1);
        base = writes;
        expect_wr(8'h02, 8'h5A);
        send_byte(8'h5A);
        repeat (20) @(negedge i_clk);
        check("busy_hold_writes", writes - base, 0);
        check("busy_hold_ready", o_ready, 0);
        check("busy_hold_pending", sb.size(), 1);
        tick(1);
        busy_mode = 0;
        wait_idle(50);
        check("busy_release_writes", writes - base, 1);
        check("busy_release_cursor", o_cursor, 8'h03);

        // SET_ADDR 0xFF then 'X','Y': wrap at the top of the address space.
        base = writes;
        send_byte(8'h01);
        send_byte(8'hFF);
        expect_wr(8'hFF, 8'h58);
        expect_wr(8'h00, 8'h59);
        send_byte(8'h58);
        send_byte(8'h59);
        wait_idle(50);
        check("wrap_writes", writes - base, 2);
        check("wrap_cursor", o_cursor, 8'h01);

        // SET_ADDR 0x10, FILL 0x2A x4 with VGA busy toggling every cycle.
        busy_mode = 2;
        base      = writes;
        send_byte(8'h01);
        send_byte(8'h10);
        for (int i = 0; i < 4; i++) expect_wr(8'h10 + 8'(i), 8'h2A);
        fill_cycles = 0;
        fill_busy   = 0;
        send_byte(8'h02);
        send_byte(8'h2A);
        send_byte(8'h04);
        wait_idle(50);
        busy_mode = 0;
        check("tog_writes", writes - base, 4);
        check("tog_stall_accounting", fill_cycles, 4 + fill_busy);
        check("tog_stalls_present", (fill_busy >= 3 && fill_busy <= 4), 1);
        check("tog_cursor", o_cursor, 8'h14);
        tick(2);

        // CLEAR: 256 blanks from address 0, cursor back to 0.
        base = writes;
        for (int i = 0; i < 256; i++) expect_wr(8'(i), 8'h20);
        fill_cycles = 0;
        fill_busy   = 0;
        send_byte(8'h0C);
        wait_idle(400);
        check("clr_writes", writes - base, 256);
        check("clr_fill_cycles", fill_cycles, 256);
        check("clr_cursor", o_cursor, 8'h00);

        // FILL 0x41 count 0 (=256) from 0x80: full wrap, cursor back at 0x80.
        base = writes;
        send_byte(8'h01);
        send_byte(8'h80);
        for (int i = 0; i < 256; i++) expect_wr(8'h80 + 8'(i), 8'h41);
        send_byte(8'h02);
        send_byte(8'h41);
        send_byte(8'h00);
        wait_idle(400);
        check("f256_writes", writes - base, 256);
        check("f256_cursor", o_cursor, 8'h80);

        // Reset in the middle of a FILL after exactly three writes.
        send_byte(8'h01);
        send_byte(8'h40);
        base = writes;
        for (int i = 0; i < 3; i++) expect_wr(8'h40 + 8'(i), 8'h33);
        send_byte(8'h02);
        send_byte(8'h33);
        send_byte(8'h10);
        n = 0;
        while (writes - base < 3 && n < 100) begin
            @(posedge i_clk);
            n++;
        end
        #1;
        i_rst = 1'b1;
        @(negedge i_clk);
        check("rst_mid_we", o_ram_we, 0);
        @(posedge i_clk);
        #1;
        i_rst = 1'b0;
        tick(5);
        check("rst_mid_writes", writes - base, 3);
        check("rst_mid_pending", sb.size(), 0);
        check("rst_mid_ready", o_ready, 1);
        check("rst_mid_cursor", o_cursor, 8'h00);
        check("rst_mid_fill", o_fill_active, 0);

        // Unused control code 0x05 in IDLE: consumed, no write.
        base = writes;
        send_byte(8'h05);
        tick(5);
        check("ctl_writes", writes - base, 0);
        check("ctl_ready", o_ready, 1);
        check("ctl_cursor", o_cursor, 8'h00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_labels_wr_ctrl
